alu_arbiter: RTL and testbench

//  Shares one ALU instance between NUM_REQ requesters (e.g. execute stage, branch-target calc).

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// The ALU is driven combinationally from the granted requester. Its result
// and zero flag are captured into a single slot on the grant edge, then held
// until the owning requester takes them.

`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

// state    | meaning
// ST_EMPTY | no result held; any valid request may be granted
// ST_FULL  | result held for r_resp_id until that requester asserts resp_ready
module alu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = `DATA_SIZE
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic [NUM_REQ*2-1:0]      i_req_ctrl,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_in_1,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_in_2,
   output logic [NUM_REQ-1:0]        o_resp_valid,
   input  logic [NUM_REQ-1:0]        i_resp_ready,
   output logic [DATA_W-1:0]         o_resp_out,
   output logic                      o_resp_zero,
   output logic [1:0]                o_alu_ctrl,
   output logic [DATA_W-1:0]         o_alu_in_1,
   output logic [DATA_W-1:0]         o_alu_in_2,
   input  logic [DATA_W-1:0]         i_alu_out,
   input  logic                      i_alu_zero
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   r_resp_id;
   logic [DATA_W-1:0]  r_resp_out;
   logic               r_resp_zero;

   logic [IDX_W:0]     w_cand;
   logic [IDX_W-1:0]   w_grant_idx;
   logic               w_grant_found;
   logic               w_can_grant;
   logic               w_accept;
   logic [IDX_W-1:0]   w_rr_ptr_nxt;

   // Round-robin search: first valid requester starting at r_rr_ptr, wrapping.
   always_comb begin
      w_cand        = '0;
      w_grant_idx   = '0;
      w_grant_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
         if (w_cand >= NUM_REQ_W) begin
            w_cand = w_cand - NUM_REQ_W;
         end
         if (!w_grant_found && i_req_valid[w_cand[IDX_W-1:0]]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = w_cand[IDX_W-1:0];
         end
      end
   end

   // The slot is free when empty, or when its owner consumes it this cycle.
   // Reset is folded in so nothing is accepted while rst_n is low.
   assign w_can_grant  = rst_n & ((r_state == ST_EMPTY) | i_resp_ready[r_resp_id]);
   assign w_accept     = w_can_grant & w_grant_found;
   assign w_rr_ptr_nxt = (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + IDX_W'(1);

   // Grant handshake and ALU operand mux from the granted requester.
   always_comb begin
      o_req_ready = '0;
      o_alu_ctrl  = '0;
      o_alu_in_1  = '0;
      o_alu_in_2  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_accept && (w_grant_idx == IDX_W'(i))) begin
            o_req_ready[i] = 1'b1;
            o_alu_ctrl     = i_req_ctrl[2*i +: 2];
            o_alu_in_1     = i_req_in_1[DATA_W*i +: DATA_W];
            o_alu_in_2     = i_req_in_2[DATA_W*i +: DATA_W];
         end
      end
   end

   // Result valid goes only to the owner of the held slot.
   always_comb begin
      o_resp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         o_resp_valid[i] = (r_state == ST_FULL) && (r_resp_id == IDX_W'(i));
      end
   end

   assign o_resp_out  = r_resp_out;
   assign o_resp_zero = r_resp_zero;

   // Next-state: a grant always refills the slot; a consume without grant drains it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_accept) begin
               w_state_nxt = ST_FULL;
            end else if (i_resp_ready[r_resp_id]) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Result slot, owner id and round-robin pointer; all move only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_resp_id   <= '0;
         r_resp_out  <= '0;
         r_resp_zero <= 1'b0;
      end else if (w_accept) begin
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_resp_id   <= w_grant_idx;
         r_resp_out  <= i_alu_out;
         r_resp_zero <= i_alu_zero;
      end
   end

   // Handshake outputs must never address more than one requester.
   a_req_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(o_req_ready));
   a_resp_valid_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(o_resp_valid));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a 2-requester and a 3-requester instance, each
// backed by a behavioural ALU. A reference model of the arbitration rules
// is compared against both instances every cycle, and directed scenarios
// carry literal expectations for specific cycles.
module tb_alu_arbiter;

   localparam logic [1:0] OP_AND = 2'd0;
   localparam logic [1:0] OP_OR  = 2'd1;
   localparam logic [1:0] OP_ADD = 2'd2;
   localparam logic [1:0] OP_SUB = 2'd3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 2-requester instance
   logic [1:0]  a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
   logic [3:0]  a_req_ctrl;
   logic [63:0] a_in1, a_in2;
   logic [31:0] a_resp_out, a_alu_in_1, a_alu_in_2, a_alu_out;
   logic        a_resp_zero, a_alu_zero;
   logic [1:0]  a_alu_ctrl;

   // 3-requester instance
   logic [2:0]  b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
   logic [5:0]  b_req_ctrl;
   logic [95:0] b_in1, b_in2;
   logic [31:0] b_resp_out, b_alu_in_1, b_alu_in_2, b_alu_out;
   logic        b_resp_zero, b_alu_zero;
   logic [1:0]  b_alu_ctrl;

   function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      case (op)
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_ADD:  return x + y;
         default: return x - y;
      endcase
   endfunction

   assign a_alu_out  = alu_f(a_alu_ctrl, a_alu_in_1, a_alu_in_2);
   assign a_alu_zero = (a_alu_out == 32'd0);
   assign b_alu_out  = alu_f(b_alu_ctrl, b_alu_in_1, b_alu_in_2);
   assign b_alu_zero = (b_alu_out == 32'd0);

   alu_arbiter #(.NUM_REQ(2), .DATA_W(32)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
      .i_req_ctrl(a_req_ctrl), .i_req_in_1(a_in1), .i_req_in_2(a_in2),
      .o_resp_valid(a_resp_valid), .i_resp_ready(a_resp_ready),
      .o_resp_out(a_resp_out), .o_resp_zero(a_resp_zero),
      .o_alu_ctrl(a_alu_ctrl), .o_alu_in_1(a_alu_in_1), .o_alu_in_2(a_alu_in_2),
      .i_alu_out(a_alu_out), .i_alu_zero(a_alu_zero));

   alu_arbiter #(.NUM_REQ(3), .DATA_W(32)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
      .i_req_ctrl(b_req_ctrl), .i_req_in_1(b_in1), .i_req_in_2(b_in2),
      .o_resp_valid(b_resp_valid), .i_resp_ready(b_resp_ready),
      .o_resp_out(b_resp_out), .o_resp_zero(b_resp_zero),
      .o_alu_ctrl(b_alu_ctrl), .o_alu_in_1(b_alu_in_1), .o_alu_in_2(b_alu_in_2),
      .i_alu_out(b_alu_out), .i_alu_zero(b_alu_zero));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Per instance: is a result held, whose is it, what is it, and where the
   // next round-robin search starts.
   bit          m_full [2];
   int          m_id   [2];
   int          m_ptr  [2];
   logic [31:0] m_res  [2];
   bit          m_zero [2];
   bit          n_full [2];
   int          n_id   [2];
   int          n_ptr  [2];
   logic [31:0] n_res  [2];
   bit          n_zero [2];

   task automatic model_check(input int d, input int n,
                              input logic [2:0] rv, input logic [2:0] rr,
                              input logic [5:0] ctl, input logic [95:0] i1, input logic [95:0] i2,
                              input logic [2:0] act_rdy, input logic [2:0] act_rv,
                              input logic [31:0] act_out, input logic act_z,
                              input logic [1:0] act_ctl, input logic [31:0] act_a1,
                              input logic [31:0] act_a2);
      bit found = 0;
      int g = 0;
      bit acc;
      logic [2:0]  e_rdy = '0;
      logic [2:0]  e_rv  = '0;
      logic [1:0]  e_ctl = '0;
      logic [31:0] e_a1  = '0;
      logic [31:0] e_a2  = '0;
      string p = (d == 0) ? "a" : "b";
      if (!rst_n) begin
         m_full[d] = 0; m_id[d] = 0; m_ptr[d] = 0; m_res[d] = '0; m_zero[d] = 0;
      end
      for (int k = 0; k < n; k++) begin
         int idx = (m_ptr[d] + k) % n;
         if (!found && rv[idx]) begin
            found = 1;
            g = idx;
         end
      end
      acc = rst_n && found && (!m_full[d] || rr[m_id[d]]);
      if (acc) begin
         e_rdy[g] = 1'b1;
         e_ctl    = ctl[2*g +: 2];
         e_a1     = i1[32*g +: 32];
         e_a2     = i2[32*g +: 32];
      end
      if (m_full[d]) e_rv[m_id[d]] = 1'b1;
      chk({p, "_model_req_ready"}, 32'(act_rdy), 32'(e_rdy));
      chk({p, "_model_resp_valid"}, 32'(act_rv), 32'(e_rv));
      chk({p, "_model_resp_out"}, act_out, m_res[d]);
      chk({p, "_model_resp_zero"}, 32'(act_z), 32'(m_zero[d]));
      chk({p, "_model_alu_ctrl"}, 32'(act_ctl), 32'(e_ctl));
      chk({p, "_model_alu_in_1"}, act_a1, e_a1);
      chk({p, "_model_alu_in_2"}, act_a2, e_a2);
      n_full[d] = m_full[d]; n_id[d] = m_id[d]; n_ptr[d] = m_ptr[d];
      n_res[d]  = m_res[d];  n_zero[d] = m_zero[d];
      if (acc) begin
         n_full[d] = 1;
         n_id[d]   = g;
         n_ptr[d]  = (g + 1) % n;
         n_res[d]  = alu_f(e_ctl, e_a1, e_a2);
         n_zero[d] = (n_res[d] == 32'd0);
      end else if (m_full[d] && rr[m_id[d]]) begin
         n_full[d] = 0;
      end
   endtask

   // Compare process: check on the falling edge, advance the model on the rising edge.
   initial begin
      for (int d = 0; d < 2; d++) begin
         m_full[d] = 0; m_id[d] = 0; m_ptr[d] = 0; m_res[d] = '0; m_zero[d] = 0;
      end
      forever begin
         @(negedge clk);
         model_check(0, 2, {1'b0, a_req_valid}, {1'b0, a_resp_ready}, {2'b0, a_req_ctrl},
                     {32'b0, a_in1}, {32'b0, a_in2}, {1'b0, a_req_ready}, {1'b0, a_resp_valid},
                     a_resp_out, a_resp_zero, a_alu_ctrl, a_alu_in_1, a_alu_in_2);
         model_check(1, 3, b_req_valid, b_resp_ready, b_req_ctrl, b_in1, b_in2,
                     b_req_ready, b_resp_valid, b_resp_out, b_resp_zero,
                     b_alu_ctrl, b_alu_in_1, b_alu_in_2);
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               m_full[d] = 0; m_id[d] = 0; m_ptr[d] = 0; m_res[d] = '0; m_zero[d] = 0;
            end else begin
               m_full[d] = n_full[d]; m_id[d] = n_id[d]; m_ptr[d] = n_ptr[d];
               m_res[d]  = n_res[d];  m_zero[d] = n_zero[d];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      // T1: reset with every request valid
      rst_n = 1'b0;
      a_req_valid = 2'b11; a_req_ctrl = {OP_ADD, OP_ADD};
      a_in1 = {32'd1, 32'd2}; a_in2 = {32'd3, 32'd4}; a_resp_ready = 2'b00;
      b_req_valid = 3'b111; b_req_ctrl = {OP_ADD, OP_ADD, OP_ADD};
      b_in1 = {32'd1, 32'd2, 32'd3}; b_in2 = {32'd4, 32'd5, 32'd6}; b_resp_ready = 3'b111;
      @(negedge clk);
      chk("t1_req_ready", 32'(a_req_ready), 32'd0);
      chk("t1_resp_valid", 32'(a_resp_valid), 32'd0);
      chk("t1_alu_in_1", a_alu_in_1, 32'd0);
      chk("t1_resp_out", a_resp_out, 32'd0);
      chk("t1_b_req_ready", 32'(b_req_ready), 32'd0);
      tick();
      tick();
      rst_n = 1'b1; a_req_valid = 2'b00; b_req_valid = 3'b000;
      tick();

      // T2: single ADD 5+7 from requester 0
      a_req_valid = 2'b01; a_req_ctrl = {OP_AND, OP_ADD};
      a_in1 = {32'd0, 32'd5}; a_in2 = {32'd0, 32'd7}; a_resp_ready = 2'b00;
      @(negedge clk);
      chk("t2_req_ready", 32'(a_req_ready), 32'd1);
      chk("t2_alu_ctrl", 32'(a_alu_ctrl), 32'(OP_ADD));
      chk("t2_alu_in_1", a_alu_in_1, 32'd5);
      chk("t2_alu_in_2", a_alu_in_2, 32'd7);
      tick();
      a_req_valid = 2'b00;
      @(negedge clk);
      chk("t2_resp_valid", 32'(a_resp_valid), 32'd1);
      chk("t2_resp_out", a_resp_out, 32'd12);
      chk("t2_resp_zero", 32'(a_resp_zero), 32'd0);
      tick();
      a_resp_ready = 2'b01;
      tick();
      a_resp_ready = 2'b00;

      // T3: contention, pointer now at 1 -> grants 1,0,1,0
      a_req_valid = 2'b11; a_req_ctrl = {OP_SUB, OP_AND};
      a_in1 = {32'd9, 32'h0000_00F0}; a_in2 = {32'd9, 32'h0000_003C}; a_resp_ready = 2'b11;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("t3_grant%0d", c), 32'(a_req_ready), (c % 2 == 0) ? 32'd2 : 32'd1);
         if (c == 1) begin
            chk("t3_sub_out", a_resp_out, 32'd0);
            chk("t3_sub_zero", 32'(a_resp_zero), 32'd1);
         end
         if (c == 2) begin
            chk("t3_and_out", a_resp_out, 32'h30);
            chk("t3_and_zero", 32'(a_resp_zero), 32'd0);
         end
         tick();
      end
      a_req_valid = 2'b00;
      tick();

      // T4: backpressure on requester 0; resp_ready[1] must be ignored
      a_req_valid = 2'b01; a_req_ctrl = {OP_OR, OP_ADD};
      a_in1 = {32'h0000_00A0, 32'd100}; a_in2 = {32'h0000_0005, 32'd23};
      @(negedge clk);
      chk("t4_first_grant", 32'(a_req_ready), 32'd1);
      tick();
      a_req_valid = 2'b10; a_resp_ready = 2'b10;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("t4_stall_ready%0d", c), 32'(a_req_ready), 32'd0);
         chk($sformatf("t4_stall_out%0d", c), a_resp_out, 32'd123);
         tick();
      end
      a_resp_ready = 2'b11;
      @(negedge clk);
      chk("t4_release_grant", 32'(a_req_ready), 32'd2);
      tick();
      a_req_valid = 2'b00;
      @(negedge clk);
      chk("t4_resp_valid", 32'(a_resp_valid), 32'd2);
      chk("t4_resp_out", a_resp_out, 32'hA5);
      tick();

      // T5: 3 requesters, move pointer to 2, then wrap 2 -> 0
      b_req_valid = 3'b010; b_req_ctrl = {OP_ADD, OP_ADD, OP_ADD};
      b_in1 = {32'd3, 32'd10, 32'hFFFF_FFFF}; b_in2 = {32'd4, 32'd20, 32'd1};
      tick();
      b_req_valid = 3'b000;
      @(negedge clk);
      chk("t5_setup_out", b_resp_out, 32'd30);
      tick();
      b_req_valid = 3'b101;
      @(negedge clk);
      chk("t5_grant2", 32'(b_req_ready), 32'd4);
      tick();
      b_req_valid = 3'b001;
      @(negedge clk);
      chk("t5_resp2_valid", 32'(b_resp_valid), 32'd4);
      chk("t5_resp2_out", b_resp_out, 32'd7);
      chk("t5_grant0", 32'(b_req_ready), 32'd1);
      tick();
      b_req_valid = 3'b000;
      @(negedge clk);
      chk("t5_resp0_valid", 32'(b_resp_valid), 32'd1);
      chk("t5_wrap_out", b_resp_out, 32'd0);
      chk("t5_wrap_zero", 32'(b_resp_zero), 32'd1);
      tick();

      // T6: reset while holding a result; pointer must return to 0
      a_req_valid = 2'b01; a_req_ctrl = {OP_ADD, OP_ADD};
      a_in1 = {32'd1, 32'd1}; a_in2 = {32'd1, 32'd1}; a_resp_ready = 2'b00;
      @(negedge clk);
      chk("t6_grant", 32'(a_req_ready), 32'd1);
      tick();
      a_req_valid = 2'b00;
      @(negedge clk);
      chk("t6_full", 32'(a_resp_valid), 32'd1);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_reset_valid", 32'(a_resp_valid), 32'd0);
      chk("t6_reset_out", a_resp_out, 32'd0);
      tick();
      rst_n = 1'b1; a_req_valid = 2'b11;
      @(negedge clk);
      chk("t6_ptr_reset", 32'(a_req_ready), 32'd1);
      tick();
      a_req_valid = 2'b00; a_resp_ready = 2'b11;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
